// File: rtl/sha256_compress_if.sv
// Host-side block handshake and digest bus of the SHA-256 compression engine.
// The host wrapper uses the master view; the engine uses the slave view.
interface sha256_compress_if;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         init;
   logic [255:0] digest;
   logic         digest_valid;

   modport master (
      output blk_valid,
      output blk_data,
      output init,
      input  blk_ready,
      input  digest,
      input  digest_valid
   );

   modport slave (
      input  blk_valid,
      input  blk_data,
      input  init,
      output blk_ready,
      output digest,
      output digest_valid
   );
endinterface

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: takes 512-bit padded blocks, runs 64 rounds at one round
// per clock against an external round-constant ROM, and chains the hash state across blocks.
module sha256_compress #(
   parameter int ROUNDS = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sha256_compress_if.slave        blk,
   output logic [6:0]              k_idx,
   input  logic [31:0]             k_t,
   input  logic [255:0]            iv
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   state_t        state;
   state_t        state_next;
   logic [5:0]    t;
   logic [31:0]   h_reg [8];
   logic [31:0]   wv [8];
   logic [31:0]   w [16];
   logic [255:0]  digest_reg;
   logic          digest_valid_reg;
   logic          accept;
   logic [31:0]   t1;
   logic [31:0]   t2;
   logic [31:0]   w_next;
   logic [255:0]  h_sum;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   assign accept = blk.blk_valid && blk.blk_ready;

   // wv[0..7] hold the working variables a..h; w[0] is always the current W_t.
   always_comb begin
      t1     = wv[7] + big_sigma1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + k_t + w[0];
      t2     = big_sigma0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
      h_sum  = '0;
      for (int i = 0; i < 8; i++) begin
         h_sum[255 - 32*i -: 32] = h_reg[i] + wv[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      blk.blk_ready = 1'b0;
      k_idx         = '0;
      case (state)
         IDLE: begin
            blk.blk_ready = 1'b1;
            if (blk.blk_valid) begin
               state_next = ROUND;
            end
         end
         ROUND: begin
            k_idx = {1'b0, t};
            if (t == LAST_ROUND) begin
               state_next = FINAL;
            end
         end
         FINAL: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A reset in the middle of a block discards everything, so no partial digest survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t                <= '0;
         digest_reg       <= '0;
         digest_valid_reg <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            h_reg[i] <= '0;
            wv[i]    <= '0;
         end
         for (int i = 0; i < 16; i++) begin
            w[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int i = 0; i < 16; i++) begin
                     w[i] <= blk.blk_data[511 - 32*i -: 32];
                  end
                  for (int i = 0; i < 8; i++) begin
                     if (blk.init) begin
                        h_reg[i] <= iv[255 - 32*i -: 32];
                        wv[i]    <= iv[255 - 32*i -: 32];
                     end else begin
                        wv[i]    <= h_reg[i];
                     end
                  end
                  t                <= '0;
                  digest_valid_reg <= 1'b0;
               end
            end
            ROUND: begin
               wv[7] <= wv[6];
               wv[6] <= wv[5];
               wv[5] <= wv[4];
               wv[4] <= wv[3] + t1;
               wv[3] <= wv[2];
               wv[2] <= wv[1];
               wv[1] <= wv[0];
               wv[0] <= t1 + t2;
               for (int i = 0; i < 15; i++) begin
                  w[i] <= w[i + 1];
               end
               w[15] <= w_next;
               if (t != LAST_ROUND) begin
                  t <= t + 6'd1;
               end
            end
            FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  h_reg[i] <= h_sum[255 - 32*i -: 32];
               end
               digest_reg       <= h_sum;
               digest_valid_reg <= 1'b1;
            end
            default: begin
               t <= '0;
            end
         endcase
      end
   end

   assign blk.digest       = digest_reg;
   assign blk.digest_valid = digest_valid_reg;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress: drives reference blocks, models the round-constant ROM,
// and checks the outputs every cycle against a plain-arithmetic SHA-256 model.
`timescale 1ns/1ps
module tb_sha256_compress;

   logic          clk;
   logic          rst_n;
   logic [6:0]    k_idx;
   logic [31:0]   k_t;
   logic [255:0]  iv;

   sha256_compress_if blk();

   sha256_compress dut (
      .clk   (clk),
      .rst_n (rst_n),
      .blk   (blk),
      .k_idx (k_idx),
      .k_t   (k_t),
      .iv    (iv)
   );

   logic [31:0] ktab [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV_CONST  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   // Round-constant ROM seen by the engine: combinational lookup of k_idx.
   assign k_t = (k_idx < 7'd64) ? ktab[k_idx[5:0]] : 32'h0;
   assign iv  = IV_CONST;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 compression with a fully expanded 64-word schedule.
   function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] m);
      logic [31:0] ws [64];
      logic [31:0] v [8];
      logic [31:0] s0, s1, ch, mj, x1, x2;
      logic [255:0] res;
      for (int i = 0; i < 16; i++) ws[i] = m[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rr(ws[i-15], 7) ^ rr(ws[i-15], 18) ^ (ws[i-15] >> 3);
         s1 = rr(ws[i-2], 17) ^ rr(ws[i-2], 19) ^ (ws[i-2] >> 10);
         ws[i] = ws[i-16] + s0 + ws[i-7] + s1;
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int r = 0; r < 64; r++) begin
         s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
         ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
         x1 = v[7] + s1 + ch + ktab[r] + ws[r];
         s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
         mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
         x2 = s0 + mj;
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
      end
      res = '0;
      for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: wait bound expired", name);
   endtask

   // Per-cycle scoreboard: the model tracks cycles since accept and the chained hash.
   int           m_cnt = -1;
   logic [255:0] m_h = '0;
   logic [255:0] m_digest = '0;
   logic [255:0] m_pending = '0;
   logic         m_dv = 1'b0;

   initial begin : compare_proc
      logic       exp_ready;
      logic [6:0] exp_kidx;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (!rst_n) begin
               m_cnt = -1; m_h = '0; m_digest = '0; m_dv = 1'b0;
            end
            exp_ready = (m_cnt < 0);
            exp_kidx  = (m_cnt >= 0 && m_cnt < 64) ? 7'(m_cnt) : 7'd0;
            checkOutput("cyc_blk_ready", 256'(blk.blk_ready), 256'(exp_ready));
            checkOutput("cyc_k_idx", 256'(k_idx), 256'(exp_kidx));
            checkOutput("cyc_digest_valid", 256'(blk.digest_valid), 256'(m_dv));
            checkOutput("cyc_digest", blk.digest, m_digest);
            if (rst_n) begin
               if (m_cnt < 0) begin
                  if (blk.blk_valid) begin
                     m_pending = model_compress(blk.init ? IV_CONST : m_h, blk.blk_data);
                     if (blk.init) m_h = IV_CONST;
                     m_dv  = 1'b0;
                     m_cnt = 0;
                  end
               end else if (m_cnt == 64) begin
                  m_cnt    = -1;
                  m_h      = m_pending;
                  m_digest = m_pending;
                  m_dv     = 1'b1;
               end else begin
                  m_cnt++;
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [511:0] d, input logic ini, input logic hold, output int acc_cyc);
      int n;
      @(negedge clk);
      #1;
      blk.blk_valid = 1'b1;
      blk.blk_data  = d;
      blk.init      = ini;
      n = 0;
      while (!blk.blk_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         timeoutFail("accept_wait");
         blk.blk_valid = 1'b0;
         acc_cyc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         if (!hold) blk.blk_valid = 1'b0;
      end
   endtask

   task automatic waitDigest(output int dv_cyc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!blk.digest_valid && n < 300);
      if (!blk.digest_valid) begin
         timeoutFail("digest_wait");
         dv_cyc = -1;
      end else begin
         dv_cyc = cyc;
      end
   endtask

   initial begin : main_proc
      int a0, a1, d0, d1, n;
      rst_n         = 1'b1;
      blk.blk_valid = 1'b0;
      blk.blk_data  = '0;
      blk.init      = 1'b0;
      #1 rst_n = 1'b0;
      #1 mon_en = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      #1;

      checkOutput("reset_blk_ready", 256'(blk.blk_ready), 256'd1);
      checkOutput("reset_k_idx", 256'(k_idx), 256'd0);
      checkOutput("reset_digest", blk.digest, 256'd0);
      checkOutput("reset_digest_valid", 256'(blk.digest_valid), 256'd0);

      checkOutput("model_empty", model_compress(IV_CONST, EMPTY_BLK), EMPTY_DIG);
      checkOutput("model_abc", model_compress(IV_CONST, ABC_BLK), ABC_DIG);
      checkOutput("model_two", model_compress(model_compress(IV_CONST, TWO_BLK1), TWO_BLK2), TWO_DIG);

      $display("[TB] empty message");
      applyStimulus(EMPTY_BLK, 1'b1, 1'b0, a0);
      waitDigest(d0);
      checkOutput("empty_latency", 256'(d0 - a0), 256'd65);
      checkOutput("empty_digest", blk.digest, EMPTY_DIG);

      $display("[TB] abc");
      applyStimulus(ABC_BLK, 1'b1, 1'b0, a0);
      waitDigest(d0);
      checkOutput("abc_digest", blk.digest, ABC_DIG);

      $display("[TB] two-block message");
      applyStimulus(TWO_BLK1, 1'b1, 1'b0, a0);
      waitDigest(d0);
      applyStimulus(TWO_BLK2, 1'b0, 1'b0, a1);
      checkOutput("two_dv_drop", 256'(blk.digest_valid), 256'd0);
      waitDigest(d1);
      checkOutput("two_digest", blk.digest, TWO_DIG);

      $display("[TB] backpressure");
      applyStimulus(ABC_BLK, 1'b1, 1'b0, a0);
      repeat (10) @(negedge clk);
      #1;
      blk.blk_valid = 1'b1;
      blk.blk_data  = EMPTY_BLK;
      blk.init      = 1'b1;
      waitDigest(d0);
      checkOutput("bp_first_latency", 256'(d0 - a0), 256'd65);
      checkOutput("bp_first_digest", blk.digest, ABC_DIG);
      @(posedge clk);
      #1;
      blk.blk_valid = 1'b0;
      checkOutput("bp_held_accepted", 256'(blk.blk_ready), 256'd0);
      waitDigest(d1);
      checkOutput("bp_second_spacing", 256'(d1 - d0), 256'd66);
      checkOutput("bp_second_digest", blk.digest, EMPTY_DIG);

      $display("[TB] reset mid-operation");
      applyStimulus(ABC_BLK, 1'b1, 1'b0, a0);
      n = 0;
      while (k_idx != 7'd30 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 100) timeoutFail("round30_wait");
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_blk_ready", 256'(blk.blk_ready), 256'd1);
      checkOutput("midrst_k_idx", 256'(k_idx), 256'd0);
      checkOutput("midrst_digest", blk.digest, 256'd0);
      checkOutput("midrst_digest_valid", 256'(blk.digest_valid), 256'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(ABC_BLK, 1'b1, 1'b0, a0);
      waitDigest(d0);
      checkOutput("midrst_abc_digest", blk.digest, ABC_DIG);

      $display("[TB] back-to-back");
      applyStimulus(ABC_BLK, 1'b1, 1'b1, a0);
      blk.blk_data = EMPTY_BLK;
      blk.init     = 1'b1;
      waitDigest(d0);
      checkOutput("b2b_first_latency", 256'(d0 - a0), 256'd65);
      checkOutput("b2b_first_digest", blk.digest, ABC_DIG);
      @(posedge clk);
      #1;
      blk.blk_valid = 1'b0;
      checkOutput("b2b_second_accept", 256'(blk.blk_ready), 256'd0);
      waitDigest(d1);
      checkOutput("b2b_second_spacing", 256'(d1 - d0), 256'd66);
      checkOutput("b2b_second_digest", blk.digest, EMPTY_DIG);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
